// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared slot-state encoding and sizing for the ESM issue scheduler
package esm_pkg;

  // Default number of instruction buffer slots.
  localparam int ESM_BS = 16;

  // Per-slot lifecycle: FREE -> WAIT (allocated) -> ISSUED (sent to execute) -> FREE.
  typedef enum logic [1:0] {
    SLOT_FREE   = 2'b00,
    SLOT_WAIT   = 2'b01,
    SLOT_ISSUED = 2'b10
  } slot_state_t;

endpackage

// File: rtl/esm_prio_pick.sv
// rtl/esm_prio_pick.sv - rotating-base find-first-set picker
module esm_prio_pick #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] base,
  output logic [W-1:0] grant_idx,
  output logic         any
);

  logic [W-1:0] cand;

  // Walk the request vector starting at base, wrapping once; the first set bit wins.
  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(base) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        grant_idx = cand;
      end
    end
  end

endmodule

// File: rtl/esm_issue_scheduler.sv
// rtl/esm_issue_scheduler.sv - out-of-order issue scheduler (ESM_RR_ISSUE_EN selects round-robin issue)
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter int BS    = ESM_BS,
  parameter int IDX_W = $clog2(BS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_index,
  input  logic [BS-1:0]    alloc_deps,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [IDX_W-1:0] issue_index,
  input  logic             complete_valid,
  input  logic [IDX_W-1:0] complete_index,
  output logic [IDX_W:0]   occupancy,
  output logic             full,
  output logic             empty,
  output logic             protocol_err
);

  slot_state_t           state_q [BS];
  slot_state_t           state_d [BS];
  logic [BS-1:0][BS-1:0] dep_q;
  logic [BS-1:0][BS-1:0] dep_d;

  logic [BS-1:0]    free_mask;
  logic [BS-1:0]    ready_mask;
  logic [BS-1:0]    complete_mask;
  logic [BS-1:0]    self_mask;

  logic [IDX_W:0]   occ_q;
  logic [IDX_W:0]   occ_d;
  logic             err_q;
  logic             lock_q;
  logic [IDX_W-1:0] lock_idx_q;

  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] ready_idx;
  logic [IDX_W-1:0] ready_base;
  logic             free_any;
  logic             ready_any;

  logic             alloc_hs;
  logic             issue_hs;
  logic             complete_ok;

  // Per-slot status vectors derived from registered state only.
  always_comb begin
    free_mask  = '0;
    ready_mask = '0;
    for (int i = 0; i < BS; i++) begin
      free_mask[i]  = (state_q[i] == SLOT_FREE);
      ready_mask[i] = (state_q[i] == SLOT_WAIT) && (dep_q[i] == '0);
    end
  end

  // Allocation always takes the lowest free slot.
  esm_prio_pick #(
    .N (BS),
    .W (IDX_W)
  ) u_free_pick (
    .req       (free_mask),
    .base      ({IDX_W{1'b0}}),
    .grant_idx (free_idx),
    .any       (free_any)
  );

`ifdef ESM_RR_ISSUE_EN
  logic [IDX_W-1:0] rr_ptr_q;

  // Round-robin pointer advances past each slot that is handed to execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (issue_hs) begin
      rr_ptr_q <= issue_index + IDX_W'(1);
    end
  end

  assign ready_base = rr_ptr_q;
`else
  assign ready_base = '0;
`endif

  esm_prio_pick #(
    .N (BS),
    .W (IDX_W)
  ) u_ready_pick (
    .req       (ready_mask),
    .base      (ready_base),
    .grant_idx (ready_idx),
    .any       (ready_any)
  );

  // free_any is set exactly when occupancy is below BS, i.e. alloc_ready == ~full.
  assign alloc_ready = free_any;
  assign alloc_index = free_idx;
  assign alloc_hs    = alloc_valid && alloc_ready;

  // A stalled offer stays pinned to the same slot until execute takes it.
  assign issue_valid = lock_q || ready_any;
  assign issue_index = lock_q ? lock_idx_q : ready_idx;
  assign issue_hs    = issue_valid && issue_ready;

  // Only a completion against an ISSUED slot is acted on.
  assign complete_ok   = complete_valid && (state_q[complete_index] == SLOT_ISSUED);
  assign complete_mask = complete_ok ? ({{(BS-1){1'b0}}, 1'b1} << complete_index) : '0;
  assign self_mask     = {{(BS-1){1'b0}}, 1'b1} << alloc_index;

  // Next slot state and dependency matrix: completion, issue and allocation touch distinct slots.
  always_comb begin
    for (int i = 0; i < BS; i++) begin
      state_d[i] = state_q[i];
    end
    dep_d = dep_q;
    if (complete_ok) begin
      state_d[complete_index] = SLOT_FREE;
      for (int i = 0; i < BS; i++) begin
        dep_d[i][complete_index] = 1'b0;
      end
    end
    if (issue_hs) begin
      state_d[issue_index] = SLOT_ISSUED;
    end
    if (alloc_hs) begin
      state_d[alloc_index] = SLOT_WAIT;
      dep_d[alloc_index]   = alloc_deps & ~free_mask & ~complete_mask & ~self_mask;
    end
  end

  // Slot state and dependency registers; reset discards every in-flight slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BS; i++) begin
        state_q[i] <= SLOT_FREE;
      end
      dep_q <= '0;
    end else begin
      for (int i = 0; i < BS; i++) begin
        state_q[i] <= state_d[i];
      end
      dep_q <= dep_d;
    end
  end

  assign occ_d = occ_q + {{IDX_W{1'b0}}, alloc_hs} - {{IDX_W{1'b0}}, complete_ok};

  // Occupancy counter; cannot wrap since alloc stops at BS and bad completes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  // Sticky error on any completion that names a slot not in ISSUED.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (complete_valid && !complete_ok) begin
      err_q <= 1'b1;
    end
  end

  // Capture the offered slot when execute stalls; release on the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else if (issue_valid && !issue_ready) begin
      lock_q     <= 1'b1;
      lock_idx_q <= issue_index;
    end else if (issue_hs) begin
      lock_q     <= 1'b0;
    end
  end

  assign occupancy    = occ_q;
  assign full         = (occ_q == (IDX_W+1)'(BS));
  assign empty        = (occ_q == '0);
  assign protocol_err = err_q;

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// tb/tb_esm_issue_scheduler.sv - directed self-checking bench for esm_issue_scheduler
module tb_esm_issue_scheduler;

  localparam int BS    = 16;
  localparam int IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic             alloc_valid;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_index;
  logic [BS-1:0]    alloc_deps;
  logic             issue_valid;
  logic             issue_ready;
  logic [IDX_W-1:0] issue_index;
  logic             complete_valid;
  logic [IDX_W-1:0] complete_index;
  logic [IDX_W:0]   occupancy;
  logic             full;
  logic             empty;
  logic             protocol_err;

  int n_tests;
  int n_fail;
  int exp_order [3];

  esm_issue_scheduler #(.BS(BS)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .alloc_valid    (alloc_valid),
    .alloc_ready    (alloc_ready),
    .alloc_index    (alloc_index),
    .alloc_deps     (alloc_deps),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .issue_index    (issue_index),
    .complete_valid (complete_valid),
    .complete_index (complete_index),
    .occupancy      (occupancy),
    .full           (full),
    .empty          (empty),
    .protocol_err   (protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alloc_valid    = 1'b0;
    alloc_deps     = '0;
    issue_ready    = 1'b0;
    complete_valid = 1'b0;
    complete_index = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b1;
    do_reset();

    // Reset state
    check_eq("rst_occ", occupancy, 0);
    check_eq("rst_issue_valid", issue_valid, 0);
    check_eq("rst_alloc_ready", alloc_ready, 1);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_perr", protocol_err, 0);

    // A into slot 0, B depends on A
    alloc_valid = 1'b1; alloc_deps = 16'h0000; #1;
    check_eq("a_index", alloc_index, 0);
    check_eq("a_no_issue_same_cycle", issue_valid, 0);
    tick();
    alloc_deps = 16'h0001; #1;
    check_eq("b_index", alloc_index, 1);
    check_eq("a_issue_valid", issue_valid, 1);
    check_eq("a_issue_index", issue_index, 0);
    issue_ready = 1'b1;
    tick();
    alloc_valid = 1'b0; #1;
    check_eq("b_blocked", issue_valid, 0);
    check_eq("occ_two", occupancy, 2);
    tick();
    check_eq("b_still_blocked", issue_valid, 0);
    complete_valid = 1'b1; complete_index = 4'd0; #1;
    check_eq("b_blocked_in_complete_cycle", issue_valid, 0);
    tick();
    complete_valid = 1'b0; #1;
    check_eq("b_ready_after_complete", issue_valid, 1);
    check_eq("b_issue_index", issue_index, 1);
    check_eq("occ_after_complete", occupancy, 1);
    tick();
    issue_ready = 1'b0;
    complete_valid = 1'b1; complete_index = 4'd1;
    tick();
    complete_valid = 1'b0; #1;
    check_eq("empty_after_drain", empty, 1);

    // Fill all slots
    do_reset();
    for (int i = 0; i < BS; i++) begin
      alloc_valid = 1'b1; alloc_deps = '0; #1;
      check_eq($sformatf("fill_index_%0d", i), alloc_index, i);
      tick();
    end
    check_eq("fill_full", full, 1);
    check_eq("fill_alloc_ready", alloc_ready, 0);
    check_eq("fill_occ", occupancy, 16);
    tick();
    check_eq("overflow_ignored", occupancy, 16);
    alloc_valid = 1'b0; #1;
    check_eq("fill_issue_index", issue_index, 0);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    complete_valid = 1'b1; complete_index = 4'd0;
    tick();
    complete_valid = 1'b0; #1;
    check_eq("refill_alloc_ready", alloc_ready, 1);
    check_eq("refill_full", full, 0);
    check_eq("refill_occ", occupancy, 15);
    check_eq("refill_index", alloc_index, 0);

    // Locked offer of slot 5 while others become ready
    do_reset();
    alloc_valid = 1'b1; alloc_deps = 16'h0000;
    tick();
    alloc_deps = 16'h0001; issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    alloc_deps = 16'h0000;
    tick();
    alloc_valid = 1'b0; #1;
    check_eq("lock_offer_valid", issue_valid, 1);
    check_eq("lock_offer_index", issue_index, 5);
    complete_valid = 1'b1; complete_index = 4'd0;
    tick();
    complete_valid = 1'b0; #1;
    check_eq("lock_hold_1", issue_index, 5);
    tick();
    check_eq("lock_hold_2", issue_index, 5);
    issue_ready = 1'b1; #1;
    check_eq("lock_hs_index", issue_index, 5);
    tick();
    issue_ready = 1'b0; #1;
    check_eq("lock_released_next", issue_index, 1);

    // Issue selection order
`ifdef ESM_RR_ISSUE_EN
    exp_order[0] = 2; exp_order[1] = 3; exp_order[2] = 0;
`else
    exp_order[0] = 0; exp_order[1] = 2; exp_order[2] = 3;
`endif
    do_reset();
    alloc_valid = 1'b1; alloc_deps = 16'h0000;
    tick();
    issue_ready = 1'b1; #1;
    check_eq("order_first", issue_index, 0);
    tick();
    alloc_deps = 16'h0002; #1;
    check_eq("order_second", issue_index, 1);
    tick();
    issue_ready = 1'b0;
    tick();
    alloc_valid = 1'b0; complete_valid = 1'b1; complete_index = 4'd0;
    tick();
    complete_valid = 1'b0; alloc_valid = 1'b1; alloc_deps = 16'h0002; #1;
    check_eq("realloc_index", alloc_index, 0);
    tick();
    alloc_valid = 1'b0; complete_valid = 1'b1; complete_index = 4'd1; #1;
    check_eq("order_all_blocked", issue_valid, 0);
    tick();
    complete_valid = 1'b0; issue_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("order_pick_%0d", i), issue_index, exp_order[i]);
      tick();
    end
    issue_ready = 1'b0;

    // Protocol error and simultaneous alloc + complete
    do_reset();
    complete_valid = 1'b1; complete_index = 4'd7; #1;
    check_eq("perr_not_yet", protocol_err, 0);
    tick();
    complete_valid = 1'b0; #1;
    check_eq("perr_set", protocol_err, 1);
    check_eq("perr_occ", occupancy, 0);
    tick();
    check_eq("perr_sticky", protocol_err, 1);
    alloc_valid = 1'b1; alloc_deps = '0;
    tick();
    alloc_valid = 1'b0; issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    alloc_valid = 1'b1; complete_valid = 1'b1; complete_index = 4'd0; #1;
    check_eq("simul_alloc_index", alloc_index, 1);
    tick();
    alloc_valid = 1'b0; complete_valid = 1'b0; #1;
    check_eq("simul_occ", occupancy, 1);
    check_eq("pre_reset_issue_valid", issue_valid, 1);

    // Asynchronous reset mid-traffic
    rst_n = 1'b0; #1;
    check_eq("midrst_occ", occupancy, 0);
    check_eq("midrst_issue_valid", issue_valid, 0);
    check_eq("midrst_alloc_ready", alloc_ready, 1);
    check_eq("midrst_perr", protocol_err, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
